// File: rtl/ip_recv_v2.sv
// ---------------------------------------------------------------------------
// ip_recv_v2 -- IPv4 header parser for the Ethernet receive path.
//
// Takes the IP datagram one byte per clock from the MAC receive stage and
// checks the header: version, IHL, total length, fragmentation, protocol and
// destination address. When a header is accepted, the addressing and length
// fields are committed and 'active' marks exactly the payload bytes for the
// downstream ICMP/UDP receivers.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-high reset
//   rx_enable    in   high while datagram bytes stream, low between frames
//   data[7:0]    in   datagram byte, valid when rx_enable=1
//   broadcast    in   frame carried the MAC broadcast address (frame-stable)
//   local_ip     in   own IPv4 address
//   subnet_mask  in   own netmask
//   active       out  current data byte is payload (combinational)
//   is_icmp      out  committed protocol == 1
//   is_udp       out  committed protocol == 17
//   is_igmp      out  committed protocol == 2 (0 unless ACCEPT_IGMP)
//   remote_ip    out  committed source address
//   to_ip        out  committed destination address
//   payload_len  out  committed total_length - header_len
//   hdr_error    out  one-cycle pulse on malformed-header rejection
//
// Optional build macro:
//   IP_RX_CSUM_EN  verify the header ones-complement checksum at header end
//                  (a mismatch rejects with hdr_error and no commit).
// ---------------------------------------------------------------------------
module ip_recv_v2 #(
    parameter int LEN_W        = 11,
    parameter bit ACCEPT_MCAST = 1'b0,
    parameter bit ACCEPT_IGMP  = 1'b0,
    parameter bit ALLOW_FRAG   = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_enable,
    input  logic [7:0]       data,
    input  logic             broadcast,
    input  logic [31:0]      local_ip,
    input  logic [31:0]      subnet_mask,
    output logic             active,
    output logic             is_icmp,
    output logic             is_udp,
    output logic             is_igmp,
    output logic [31:0]      remote_ip,
    output logic [31:0]      to_ip,
    output logic [LEN_W-1:0] payload_len,
    output logic             hdr_error
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DONE} state_t;

    state_t           state_q;
    logic [LEN_W-1:0] byte_no_q;   // number of datagram bytes already consumed
    logic [LEN_W-1:0] tot_len_q;
    logic [5:0]       hdr_len_q;
    logic [7:0]       tl_hi_q;
    logic [7:0]       proto_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;

    logic             is_icmp_q, is_udp_q, is_igmp_q, hdr_error_q;
    logic [31:0]      remote_ip_q, to_ip_q;
    logic [LEN_W-1:0] payload_len_q;

    // Combinational views of the byte currently on 'data'.
    logic [LEN_W-1:0] byte_no_d;   // 1-based number of the current byte
    logic [LEN_W-1:0] hdr_len_d;
    logic [15:0]      tot_len16_d;
    logic [31:0]      dst_d;
    logic             tl_too_big_d;
    logic             proto_ok_d;
    logic             dst_ok_d;
    logic             at_hdr_end_d;
    logic             csum_ok_d;

`ifdef IP_RX_CSUM_EN
    logic [15:0] csum_q;
    logic [7:0]  csum_hi_q;
    logic [15:0] csum_d;

    // Ones-complement add with end-around carry; a single fold suffices
    // because 0xFFFF + 0xFFFF folds to 0xFFFF without a second carry.
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // The last header word completes on an even byte, so csum_d already
    // includes it when the header-end decision is taken.
    always_comb begin
        csum_d    = csum_add(csum_q, {csum_hi_q, data});
        csum_ok_d = (csum_d == 16'hFFFF);
    end
`else
    assign csum_ok_d = 1'b1;
`endif

    always_comb begin
        byte_no_d    = byte_no_q + LEN_W'(1);
        hdr_len_d    = LEN_W'(hdr_len_q);
        tot_len16_d  = {tl_hi_q, data};
        dst_d        = {dst_q[23:0], data};
        tl_too_big_d = ((32'(tot_len16_d) >> LEN_W) != 32'd0);
        proto_ok_d   = (data == 8'd1) || (data == 8'd17) ||
                       (ACCEPT_IGMP && (data == 8'd2));
        if (broadcast) begin
            // Limited broadcast, our own address, or our directed broadcast.
            dst_ok_d = (dst_d == 32'hFFFF_FFFF) || (dst_d == local_ip) ||
                       (((dst_d & subnet_mask) == (local_ip & subnet_mask)) &&
                        ((dst_d | subnet_mask) == 32'hFFFF_FFFF));
        end else begin
            dst_ok_d = (dst_d[31:28] != 4'hE) || ACCEPT_MCAST;
        end
        at_hdr_end_d = (byte_no_d == hdr_len_d);
    end

    assign active      = rx_enable && (state_q == PAYLOAD);
    assign is_icmp     = is_icmp_q;
    assign is_udp      = is_udp_q;
    assign is_igmp     = is_igmp_q;
    assign remote_ip   = remote_ip_q;
    assign to_ip       = to_ip_q;
    assign payload_len = payload_len_q;
    assign hdr_error   = hdr_error_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            byte_no_q     <= '0;
            tot_len_q     <= '0;
            hdr_len_q     <= '0;
            tl_hi_q       <= '0;
            proto_q       <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            is_icmp_q     <= 1'b0;
            is_udp_q      <= 1'b0;
            is_igmp_q     <= 1'b0;
            hdr_error_q   <= 1'b0;
            remote_ip_q   <= '0;
            to_ip_q       <= '0;
            payload_len_q <= '0;
`ifdef IP_RX_CSUM_EN
            csum_q        <= '0;
            csum_hi_q     <= '0;
`endif
        end else begin
            hdr_error_q <= 1'b0;
            if (!rx_enable) begin
                state_q   <= IDLE;
                byte_no_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // First datagram byte: version / IHL.
                        byte_no_q <= LEN_W'(1);
`ifdef IP_RX_CSUM_EN
                        csum_q    <= '0;
                        csum_hi_q <= data;
`endif
                        if (data[7:4] != 4'd4) begin
                            state_q <= DONE;
                        end else if (data[3:0] < 4'd5) begin
                            state_q     <= DONE;
                            hdr_error_q <= 1'b1;
                        end else begin
                            hdr_len_q <= {data[3:0], 2'b00};
                            state_q   <= HEADER;
                        end
                    end

                    HEADER: begin
                        byte_no_q <= byte_no_d;
`ifdef IP_RX_CSUM_EN
                        if (byte_no_d[0]) csum_hi_q <= data;
                        else              csum_q    <= csum_d;
`endif
                        if (byte_no_d == LEN_W'(3)) tl_hi_q <= data;
                        if (byte_no_d == LEN_W'(4)) begin
                            tot_len_q <= LEN_W'(tot_len16_d);
                            if (tl_too_big_d) begin
                                state_q     <= DONE;
                                hdr_error_q <= 1'b1;
                            end
                        end
                        if ((byte_no_d == LEN_W'(5)) && (tot_len_q < hdr_len_d)) begin
                            state_q     <= DONE;
                            hdr_error_q <= 1'b1;
                        end
                        // Byte 7 holds MF (bit 5) and offset[12:8]; byte 8 offset[7:0].
                        if (!ALLOW_FRAG && (byte_no_d == LEN_W'(7)) &&
                            (data[5] || (data[4:0] != 5'd0)))
                            state_q <= DONE;
                        if (!ALLOW_FRAG && (byte_no_d == LEN_W'(8)) && (data != 8'd0))
                            state_q <= DONE;
                        if (byte_no_d == LEN_W'(10)) begin
                            proto_q <= data;
                            if (!proto_ok_d) state_q <= DONE;
                        end
                        if ((byte_no_d >= LEN_W'(13)) && (byte_no_d <= LEN_W'(16)))
                            src_q <= {src_q[23:0], data};
                        if ((byte_no_d >= LEN_W'(17)) && (byte_no_d <= LEN_W'(20)))
                            dst_q <= dst_d;

                        // Header end is never before byte 20, so a destination
                        // reject on byte 20 must pre-empt the commit.
                        if ((byte_no_d == LEN_W'(20)) && !dst_ok_d) begin
                            state_q <= DONE;
                        end else if (at_hdr_end_d) begin
                            if (!csum_ok_d) begin
                                state_q     <= DONE;
                                hdr_error_q <= 1'b1;
                            end else begin
                                remote_ip_q   <= src_q;
                                to_ip_q       <= (byte_no_d == LEN_W'(20)) ? dst_d : dst_q;
                                is_icmp_q     <= (proto_q == 8'd1);
                                is_udp_q      <= (proto_q == 8'd17);
                                is_igmp_q     <= ACCEPT_IGMP && (proto_q == 8'd2);
                                payload_len_q <= tot_len_q - hdr_len_d;
                                state_q       <= (tot_len_q == hdr_len_d) ? DONE : PAYLOAD;
                            end
                        end
                    end

                    PAYLOAD: begin
                        byte_no_q <= byte_no_d;
                        if (byte_no_d == tot_len_q) state_q <= DONE;
                    end

                    DONE: begin
                        // Swallow the rest of the frame (padding, CRC).
                    end

                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
